// File: rtl/sdf_bf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage with twiddle multiply.
// Optional macro SDF_STAGE_SAT_EN: clamp out-of-range results instead of wrapping.
module sdf_bf_stage #(
  parameter int WIDTH_IN  = 12,
  parameter int WIDTH_OUT = 13,
  parameter int DELAY     = 32,
  parameter int WIDTH_TW  = 10,
  parameter int TW_SHIFT  = 8,
  parameter int TW_ADDR_W = 9,
  parameter int TW_STRIDE = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH_IN-1:0]  in_i,
  input  logic signed [WIDTH_IN-1:0]  in_q,
  input  logic                        in_last,
  output logic [TW_ADDR_W-1:0]        tw_addr,
  input  logic signed [WIDTH_TW-1:0]  tw_re,
  input  logic signed [WIDTH_TW-1:0]  tw_im,
  output logic                        out_valid,
  output logic signed [WIDTH_OUT-1:0] out_i,
  output logic signed [WIDTH_OUT-1:0] out_q,
  output logic                        out_last,
  output logic                        ovf
);

  localparam int CW = $clog2(2 * DELAY);
  localparam int AW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int DW = WIDTH_IN + 1;
  localparam int PW = WIDTH_IN + WIDTH_TW + 3;
  localparam int RW = (PW > WIDTH_OUT) ? PW : WIDTH_OUT + 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(2 * DELAY - 1);
  localparam logic [CW-1:0] HALF_CNT  = CW'(DELAY);
  localparam logic [CW-1:0] DRAIN_END = CW'(DELAY - 1);
  localparam logic [CW-1:0] IDX_MASK  = CW'(DELAY - 1);
  localparam logic [TW_ADDR_W-1:0] STRIDE = TW_ADDR_W'(TW_STRIDE);
  localparam logic signed [RW-1:0] RND =
    (TW_SHIFT > 0) ? (RW'(1) << ((TW_SHIFT > 0) ? TW_SHIFT - 1 : 0)) : RW'(0);
`ifdef SDF_STAGE_SAT_EN
  localparam logic signed [WIDTH_OUT-1:0] OUT_MAX = {1'b0, {(WIDTH_OUT-1){1'b1}}};
  localparam logic signed [WIDTH_OUT-1:0] OUT_MIN = {1'b1, {(WIDTH_OUT-1){1'b0}}};
`endif

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   fifo_full_q, fifo_full_d;
  logic                   ovf_q, ovf_d;
  logic [TW_ADDR_W-1:0]   tw_addr_q, tw_addr_d;

  logic signed [DW-1:0]   mem_i [DELAY];
  logic signed [DW-1:0]   mem_q [DELAY];
  logic [AW-1:0]          idx_s;
  logic signed [DW-1:0]   head_i_s, head_q_s, ext_i_s, ext_q_s;
  logic signed [DW-1:0]   sum_i_s, sum_q_s, diff_i_s, diff_q_s;
  logic signed [DW-1:0]   wr_i_s, wr_q_s;
  logic                   xfer_s, fill_s, wr_en_s;
  logic                   emit_s, emit_tw_s, emit_last_s, proto_err_s;

  logic                   s1_valid_q, s1_tw_q, s1_last_q;
  logic signed [DW-1:0]   s1_i_q, s1_q_q;
  logic                   s2_valid_q, s2_tw_q, s2_last_q;
  logic signed [DW-1:0]   s2_i_q, s2_q_q;

  logic signed [RW-1:0]   prod_re_s, prod_im_s, res_i_s, res_q_s;
  logic                   range_err_s;

  logic                   out_valid_q, out_last_q;
  logic signed [WIDTH_OUT-1:0] out_i_q, out_q_q;

  function automatic logic fits(input logic signed [RW-1:0] v);
    logic [RW-WIDTH_OUT:0] hi;
    hi = v[RW-1:WIDTH_OUT-1];
    return (&hi) || (~|hi);
  endfunction

  function automatic logic signed [WIDTH_OUT-1:0] narrow(input logic signed [RW-1:0] v);
`ifdef SDF_STAGE_SAT_EN
    if (!fits(v)) begin
      return v[RW-1] ? OUT_MIN : OUT_MAX;
    end else begin
      return v[WIDTH_OUT-1:0];
    end
`else
    return v[WIDTH_OUT-1:0];
`endif
  endfunction

  assign idx_s    = AW'(cnt_q & IDX_MASK);
  assign head_i_s = mem_i[idx_s];
  assign head_q_s = mem_q[idx_s];
  assign ext_i_s  = DW'(in_i);
  assign ext_q_s  = DW'(in_q);
  assign sum_i_s  = head_i_s + ext_i_s;
  assign sum_q_s  = head_q_s + ext_q_s;
  assign diff_i_s = head_i_s - ext_i_s;
  assign diff_q_s = head_q_s - ext_q_s;
  assign xfer_s   = (state_q == ST_RUN) && in_valid;
  assign fill_s   = (cnt_q < HALF_CNT);

  // Control: counter, fill/butterfly half selection, RUN/DRAIN sequencing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fifo_full_d = fifo_full_q;
    wr_en_s     = 1'b0;
    wr_i_s      = ext_i_s;
    wr_q_s      = ext_q_s;
    emit_s      = 1'b0;
    emit_tw_s   = 1'b0;
    emit_last_s = 1'b0;
    proto_err_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (xfer_s) begin
          cnt_d   = cnt_q + CW'(1);
          wr_en_s = 1'b1;
          if (fill_s) begin
            emit_s    = fifo_full_q;
            emit_tw_s = 1'b1;
          end else begin
            wr_i_s      = diff_i_s;
            wr_q_s      = diff_q_s;
            emit_s      = 1'b1;
            fifo_full_d = fifo_full_q | (cnt_q == LAST_CNT);
          end
          // A misplaced last leaves the FIFO half-updated, so nothing is drained.
          if (in_last) begin
            state_d     = ST_DRAIN;
            cnt_d       = '0;
            proto_err_s = (cnt_q != LAST_CNT);
            fifo_full_d = (cnt_q == LAST_CNT);
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_DRAIN: begin
        emit_s      = fifo_full_q;
        emit_tw_s   = 1'b1;
        emit_last_s = (cnt_q == DRAIN_END);
        if (cnt_q == DRAIN_END) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          fifo_full_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d     = ST_RUN;
        cnt_d       = '0;
        fifo_full_d = 1'b0;
      end
    endcase
  end

  assign tw_addr_d = (emit_s && emit_tw_s) ? (TW_ADDR_W'(idx_s) * STRIDE) : tw_addr_q;

  // Twiddle multiply, round half-up, then select bypass or twiddle result.
  always_comb begin
    prod_re_s = RW'(s2_i_q) * RW'(tw_re) - RW'(s2_q_q) * RW'(tw_im);
    prod_im_s = RW'(s2_i_q) * RW'(tw_im) + RW'(s2_q_q) * RW'(tw_re);
    if (s2_tw_q) begin
      res_i_s = (prod_re_s + RND) >>> TW_SHIFT;
      res_q_s = (prod_im_s + RND) >>> TW_SHIFT;
    end else begin
      res_i_s = RW'(s2_i_q);
      res_q_s = RW'(s2_q_q);
    end
    range_err_s = s2_valid_q && (!fits(res_i_s) || !fits(res_q_s));
  end

  assign ovf_d = ovf_q | proto_err_s | range_err_s;

  // Feedback FIFO storage; contents are don't-care until the first fill.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_i[idx_s] <= wr_i_s;
      mem_q[idx_s] <= wr_q_s;
    end
  end

  // Control state and sticky overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      fifo_full_q <= 1'b0;
      ovf_q       <= 1'b0;
      tw_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fifo_full_q <= fifo_full_d;
      ovf_q       <= ovf_d;
      tw_addr_q   <= tw_addr_d;
    end
  end

  // Three-stage datapath: emit, wait for ROM data, multiply/round/register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s1_tw_q     <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_i_q      <= '0;
      s1_q_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_tw_q     <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_i_q      <= '0;
      s2_q_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
    end else begin
      s1_valid_q <= emit_s;
      s1_tw_q    <= emit_tw_s;
      s1_last_q  <= emit_s & emit_last_s;
      if (emit_s) begin
        s1_i_q <= emit_tw_s ? head_i_s : sum_i_s;
        s1_q_q <= emit_tw_s ? head_q_s : sum_q_s;
      end
      s2_valid_q  <= s1_valid_q;
      s2_tw_q     <= s1_tw_q;
      s2_last_q   <= s1_last_q;
      s2_i_q      <= s1_i_q;
      s2_q_q      <= s1_q_q;
      out_valid_q <= s2_valid_q;
      out_last_q  <= s2_valid_q & s2_last_q;
      if (s2_valid_q) begin
        out_i_q <= narrow(res_i_s);
        out_q_q <= narrow(res_q_s);
      end
    end
  end

  assign in_ready  = (state_q == ST_RUN);
  assign tw_addr   = tw_addr_q;
  assign out_valid = out_valid_q;
  assign out_i     = out_i_q;
  assign out_q     = out_q_q;
  assign out_last  = out_last_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sdf_bf_stage.sv
// Directed bench for sdf_bf_stage with DELAY=4 and a behavioural twiddle ROM.
module tb_sdf_bf_stage;
  localparam int WI = 12;
  localparam int WO = 13;
  localparam int D  = 4;
  localparam int WT = 10;
  localparam int AD = 9;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_last = 1'b0;
  logic signed [WI-1:0] in_i = '0;
  logic signed [WI-1:0] in_q = '0;
  logic                 in_ready;
  logic [AD-1:0]        tw_addr;
  logic signed [WT-1:0] tw_re, tw_im;
  logic                 out_valid, out_last, ovf;
  logic signed [WO-1:0] out_i, out_q;

  int tw_mode = 0;
  int cyc = 0;
  int rdy_low = 0;
  int n_vec = 0;
  int n_err = 0;
  int t5 = 0;
  int base = 0;
  int r0 = 0;
  int sat_v = 0;
  logic signed [31:0] cap_i[$];
  logic signed [31:0] cap_q[$];
  logic               cap_l[$];
  int                 cap_t[$];
  logic signed [31:0] exp_i [8];
  logic signed [31:0] exp_q [8];

  always #5 clk = ~clk;

  sdf_bf_stage #(
    .WIDTH_IN(WI), .WIDTH_OUT(WO), .DELAY(D), .WIDTH_TW(WT),
    .TW_SHIFT(8), .TW_ADDR_W(AD), .TW_STRIDE(1)
  ) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_i(in_i), .in_q(in_q), .in_last(in_last), .tw_addr(tw_addr),
    .tw_re(tw_re), .tw_im(tw_im), .out_valid(out_valid), .out_i(out_i),
    .out_q(out_q), .out_last(out_last), .ovf(ovf)
  );

  // Synchronous twiddle ROM: data one cycle after the address.
  always @(posedge clk) begin
    case (tw_mode)
      1: begin tw_re <= 10'sd0; tw_im <= -10'sd256; end
      2: begin tw_re <= WT'(64 * (int'(tw_addr) + 1)); tw_im <= 10'sd0; end
      3: begin tw_re <= 10'sd511; tw_im <= 10'sd511; end
      default: begin tw_re <= 10'sd256; tw_im <= 10'sd0; end
    endcase
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Output capture away from the active edge.
  always @(negedge clk) begin
    if (out_valid) begin
      cap_i.push_back(out_i);
      cap_q.push_back(out_q);
      cap_l.push_back(out_last);
      cap_t.push_back(cyc);
    end
    if (!in_ready) rdy_low = rdy_low + 1;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic send(input int vi, input int vq, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    in_i     = WI'(vi);
    in_q     = WI'(vq);
    in_last  = last;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic send_ramp(input int gap);
    for (int k = 0; k < 8; k++) begin
      send(k + 1, 0, k == 7);
      if (k == 4) t5 = cyc;
      if (gap > 0 && k < 7) idle(gap);
    end
    idle(14);
  endtask

  task automatic check_frame(input string tag, input int b);
    chk({tag, "_count"}, cap_i.size() - b, 8);
    for (int k = 0; k < 8; k++) begin
      if (b + k < cap_i.size()) begin
        chk($sformatf("%s_i%0d", tag, k), cap_i[b + k], exp_i[k]);
        chk($sformatf("%s_q%0d", tag, k), cap_q[b + k], exp_q[k]);
        chk($sformatf("%s_last%0d", tag, k), cap_l[b + k], k == 7);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    rstn     = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #2 rstn = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_tw_addr", tw_addr, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_out_i", out_i, 0);
    chk("rst_out_last", out_last, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Unity twiddles
    tw_mode = 0;
    exp_i = '{6, 8, 10, 12, -4, -4, -4, -4};
    exp_q = '{0, 0, 0, 0, 0, 0, 0, 0};
    base = cap_i.size();
    r0 = rdy_low;
    send_ramp(0);
    check_frame("unity", base);
    if (cap_t.size() > base) chk("unity_latency", cap_t[base] - t5, 3);
    chk("unity_ready_low", rdy_low - r0, 4);
    chk("unity_ovf", ovf, 0);

    // -j twiddle
    tw_mode = 1;
    exp_i = '{6, 8, 10, 12, 0, 0, 0, 0};
    exp_q = '{0, 0, 0, 0, 4, 4, 4, 4};
    base = cap_i.size();
    send_ramp(0);
    check_frame("minus_j", base);

    // Address-dependent twiddles expose ROM alignment
    tw_mode = 2;
    exp_i = '{6, 8, 10, 12, -1, -2, -3, -4};
    exp_q = '{0, 0, 0, 0, 0, 0, 0, 0};
    base = cap_i.size();
    send_ramp(0);
    check_frame("addr_ramp", base);

    // Input bubbles every other cycle
    tw_mode = 0;
    exp_i = '{6, 8, 10, 12, -4, -4, -4, -4};
    base = cap_i.size();
    send_ramp(1);
    check_frame("bubbles", base);
    if (cap_t.size() > base + 1) chk("bubbles_gap", cap_t[base + 1] - cap_t[base], 2);

    // Reset mid-frame
    for (int k = 0; k < 6; k++) send(k + 1, 0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_i", out_i, 0);
    chk("midrst_out_q", out_q, 0);
    chk("midrst_out_last", out_last, 0);
    chk("midrst_in_ready", in_ready, 1);
    base = cap_i.size();
    rstn = 1'b1;
    idle(4);
    chk("midrst_quiet", cap_i.size() - base, 0);
    base = cap_i.size();
    send_ramp(0);
    check_frame("after_rst", base);

    // Misplaced last
    r0 = rdy_low;
    for (int k = 0; k < 4; k++) send(k + 1, 0, 1'b0);
    send(5, 0, 1'b1);
    idle(10);
    chk("early_last_ovf", ovf, 1);
    chk("early_last_ready_low", rdy_low - r0, 4);
    chk("early_last_ready_back", in_ready, 1);

    // Overflow: diff 4095 times (511 + j511)
    do_reset();
    chk("pre_sat_ovf", ovf, 0);
`ifdef SDF_STAGE_SAT_EN
    sat_v = 4095;
`else
    sat_v = -18;
`endif
    tw_mode = 3;
    exp_i = '{-1, -1, -1, -1, sat_v, sat_v, sat_v, sat_v};
    exp_q = '{0, 0, 0, 0, sat_v, sat_v, sat_v, sat_v};
    base = cap_i.size();
    for (int k = 0; k < 4; k++) send(2047, 0, 1'b0);
    for (int k = 0; k < 4; k++) send(-2048, 0, k == 3);
    idle(14);
    check_frame("sat", base);
    chk("sat_ovf", ovf, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
